// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-to-read bypass and a
// per-register pending-write scoreboard that gives decode a hazard flag per read port.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]        rbusy_o,
    input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wdata_i,
    input  logic [NUM_WR-1:0]        wen_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          pend_cnt_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend, wr_hit, alloc_vec, clr, pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              set_new;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    // A same-cycle allocation beats the writeback, so a cleared bit must not also be allocated.
    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (wen_i[j]) wr_hit[waddr_i[j*ADDR_W +: ADDR_W]] = 1'b1;
        alloc_vec = '0;
        if (alloc_en_i) alloc_vec[alloc_addr_i] = 1'b1;
        if (ZERO_REG) begin
            wr_hit[0]    = 1'b0;
            alloc_vec[0] = 1'b0;
        end
        clr      = pend & wr_hit & ~alloc_vec;
        set_new  = |(alloc_vec & ~pend);
        pend_nxt = flush_i ? '0 : (pend | alloc_vec) & ~clr;
        cnt_nxt  = pend_cnt_o + (ADDR_W+1)'(set_new);
        for (int a = 0; a < DEPTH; a++)
            cnt_nxt = cnt_nxt - (ADDR_W+1)'(clr[a]);
        cnt_nxt = flush_i ? '0 : cnt_nxt;
    end

    // Ascending port order lets the highest-indexed port win an address collision.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
            pend       <= '0;
            pend_cnt_o <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wen_i[j] && !(ZERO_REG && waddr_i[j*ADDR_W +: ADDR_W] == '0))
                    regs[waddr_i[j*ADDR_W +: ADDR_W]] <= wdata_i[j*DATA_W +: DATA_W];
            pend       <= pend_nxt;
            pend_cnt_o <= cnt_nxt;
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        ra      = '0;
        rd      = '0;
        rb      = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = raddr_i[k*ADDR_W +: ADDR_W];
            rd = regs[ra];
            rb = pend[ra];
            for (int j = 0; j < NUM_WR; j++)
                if (BYPASS && wen_i[j] && waddr_i[j*ADDR_W +: ADDR_W] == ra) begin
                    rd = wdata_i[j*DATA_W +: DATA_W];
                    rb = 1'b0;
                end
            if (ZERO_REG && ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
            rdata_o[k*DATA_W +: DATA_W] = rst_i ? rd : '0;
            rbusy_o[k]                  = rst_i && rb;
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and random checks of reg_file_mp against an
// array-based model of register contents and pending bits.
module tb_reg_file_mp;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [9:0]  raddr_i;
    logic [63:0] rdata_o;
    logic [1:0]  rbusy_o;
    logic [9:0]  waddr_i;
    logic [63:0] wdata_i;
    logic [1:0]  wen_i;
    logic        alloc_en_i;
    logic [4:0]  alloc_addr_i;
    logic        flush_i;
    logic [5:0]  pend_cnt_o;

    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];

    int checks = 0;
    int fails  = 0;
    logic [31:0] mreg [32];
    bit          mpend [32];

    assign raddr_i = {ra[1], ra[0]};
    assign waddr_i = {wa[1], wa[0]};
    assign wdata_i = {wd[1], wd[0]};

    reg_file_mp dut (
        .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .rbusy_o(rbusy_o), .waddr_i(waddr_i), .wdata_i(wdata_i), .wen_i(wen_i),
        .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i), .flush_i(flush_i),
        .pend_cnt_o(pend_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            mreg[a]  = '0;
            mpend[a] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int a = 0; a < 32; a++) n += int'(mpend[a]);
        return n;
    endfunction

    // Expected read: register 0 is zero, else the newest same-cycle write, else stored state.
    task automatic check_reads();
        logic [31:0] d;
        bit b;
        for (int k = 0; k < 2; k++) begin
            d = mreg[ra[k]];
            b = mpend[ra[k]];
            for (int j = 0; j < 2; j++)
                if (wen_i[j] && wa[j] == ra[k]) begin
                    d = wd[j];
                    b = 1'b0;
                end
            if (ra[k] == 0) begin
                d = '0;
                b = 1'b0;
            end
            chk($sformatf("rdata%0d@%0d", k, ra[k]), rdata_o[k*32 +: 32], d);
            chk($sformatf("rbusy%0d@%0d", k, ra[k]), 32'(rbusy_o[k]), 32'(b));
        end
    endtask

    task automatic model_edge();
        bit hit [32];
        for (int a = 0; a < 32; a++) hit[a] = 1'b0;
        for (int j = 0; j < 2; j++)
            if (wen_i[j] && wa[j] != 0) begin
                mreg[wa[j]] = wd[j];
                hit[wa[j]]  = 1'b1;
            end
        for (int a = 1; a < 32; a++)
            if (flush_i) mpend[a] = 1'b0;
            else if (alloc_en_i && alloc_addr_i == a) mpend[a] = 1'b1;
            else if (hit[a]) mpend[a] = 1'b0;
    endtask

    task automatic cycle();
        #1 check_reads();
        @(posedge clk_i);
        model_edge();
        #1 chk("pend_cnt", 32'(pend_cnt_o), 32'(model_count()));
    endtask

    task automatic idle();
        wen_i      = '0;
        alloc_en_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        model_reset();
        idle();
        ra[0] = 5'd3; ra[1] = 5'd7; wa[0] = 5'd3; wa[1] = 5'd7;
        wd[0] = 32'h1234; wd[1] = 32'h5678; wen_i = 2'b11;
        #2;
        chk("rst_rdata", 32'(rdata_o[31:0] | rdata_o[63:32]), 32'h0);
        chk("rst_rbusy", 32'(rbusy_o), 32'h0);
        chk("rst_cnt", 32'(pend_cnt_o), 32'h0);
        @(posedge clk_i);
        #1 chk("rst_hold", 32'(rdata_o[31:0]), 32'h0);
        idle();
        #7 rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        wa[0] = 5'd3; wd[0] = 32'hDEADBEEF; wen_i = 2'b01; ra[1] = 5'd3; ra[0] = 5'd1;
        #1 chk("bypass_3", rdata_o[63:32], 32'hDEADBEEF);
        cycle();
        idle();
        #1 chk("stored_3", rdata_o[63:32], 32'hDEADBEEF);

        wa[0] = 5'd7; wd[0] = 32'h11; wa[1] = 5'd7; wd[1] = 32'h22; wen_i = 2'b11; ra[0] = 5'd7;
        #1 chk("collide_bypass", rdata_o[31:0], 32'h22);
        cycle();
        idle();
        #1 chk("collide_stored", rdata_o[31:0], 32'h22);

        wa[0] = 5'd0; wd[0] = 32'h55; wen_i = 2'b01; alloc_en_i = 1'b1; alloc_addr_i = 5'd0; ra[0] = 5'd0;
        cycle();
        idle();
        #1 chk("zero_rd", rdata_o[31:0], 32'h0);
        chk("zero_cnt", 32'(pend_cnt_o), 32'h0);

        alloc_en_i = 1'b1; alloc_addr_i = 5'd5; ra[0] = 5'd5;
        cycle();
        idle();
        #1 chk("busy5", 32'(rbusy_o[0]), 32'h1);
        chk("cnt1", 32'(pend_cnt_o), 32'h1);
        alloc_en_i = 1'b1; alloc_addr_i = 5'd9;
        cycle();
        chk("cnt2", 32'(pend_cnt_o), 32'h2);
        idle();
        wa[0] = 5'd5; wd[0] = 32'hA5; wa[1] = 5'd9; wd[1] = 32'hA9; wen_i = 2'b11; ra[0] = 5'd5;
        #1 chk("busy5_cleared", 32'(rbusy_o[0]), 32'h0);
        cycle();
        chk("cnt0", 32'(pend_cnt_o), 32'h0);
        idle();

        alloc_en_i = 1'b1; alloc_addr_i = 5'd4; wa[0] = 5'd4; wd[0] = 32'h44; wen_i = 2'b01;
        cycle();
        idle();
        ra[0] = 5'd4;
        #1 chk("reg4", rdata_o[31:0], 32'h44);
        chk("busy4", 32'(rbusy_o[0]), 32'h1);
        chk("cnt_alloc_wr", 32'(pend_cnt_o), 32'h1);
        alloc_en_i = 1'b1; alloc_addr_i = 5'd6; flush_i = 1'b1;
        cycle();
        idle();
        #1 chk("flush_cnt", 32'(pend_cnt_o), 32'h0);
        chk("flush_keep4", rdata_o[31:0], 32'h44);
        cycle();

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                ra[p] = 5'($urandom_range(0, (i < 200) ? 7 : 31));
                wa[p] = 5'($urandom_range(0, (i < 200) ? 7 : 31));
                wd[p] = $urandom;
            end
            wen_i        = 2'($urandom);
            alloc_en_i   = ($urandom_range(0, 2) != 0);
            alloc_addr_i = 5'($urandom_range(0, (i < 200) ? 7 : 31));
            flush_i      = ($urandom_range(0, 29) == 0);
            cycle();
        end

        for (int i = 0; i < 4; i++) begin
            wa[0] = 5'(i + 10); wd[0] = $urandom; wa[1] = 5'(i + 20); wd[1] = $urandom; wen_i = 2'b11;
            alloc_en_i = 1'b1; alloc_addr_i = 5'(i + 12); flush_i = 1'b0;
            cycle();
        end
        ra[0] = 5'd20; ra[1] = 5'd13;
        #2 rst_i = 1'b0;
        #1 chk("async_rdata", rdata_o[31:0] | rdata_o[63:32], 32'h0);
        chk("async_rbusy", 32'(rbusy_o), 32'h0);
        chk("async_cnt", 32'(pend_cnt_o), 32'h0);
        model_reset();
        idle();
        #3 rst_i = 1'b1;
        ra[0] = 5'd10;
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file with write-to-read bypass and a per-register pending-write scoreboard. It generalises the single-write, two-read integer register file: configurable data width, depth, read-port count and write-port count. It sits between decode (reads, allocation) and the writeback stages (possibly several, e.g. ALU plus a long-latency load/mul port), and gives decode a hazard flag per read port.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 is hardwired to zero: never written, never pending
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
raddr_i  in  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rdata_o  out  NUM_RD*DATA_W  read data, combinational; port k = [k*DATA_W +: DATA_W]
rbusy_o  out  NUM_RD  port k register has an outstanding write not satisfied this cycle
waddr_i  in  NUM_WR*ADDR_W  write addresses, packed as for raddr_i
wdata_i  in  NUM_WR*DATA_W  write data
wen_i  in  NUM_WR  per-port write enable
alloc_en_i  in  1  mark alloc_addr_i pending (issue of an instruction with a destination)
alloc_addr_i  in  ADDR_W  register to mark pending
flush_i  in  1  clear all pending bits (pipeline flush); register contents are kept
pend_cnt_o  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (rst_i low, async): all registers = 0, all pending bits = 0, pend_cnt_o = 0. With reset asserted rdata_o = 0 and rbusy_o = 0 for every port. Reset mid-operation discards in-flight writes and allocations immediately.
- Write: at rising edge, for each port j with wen_i[j], reg[waddr_j] <= wdata_j. Same address on several enabled ports: the highest port index wins, and lower ports are ignored for that address. If ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational): rdata_k = 0 if ZERO_REG and raddr_k==0. Else, if BYPASS and some enabled write port targets raddr_k this cycle, the data from the highest such port. Else reg[raddr_k]. Write-then-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Pending bits, next state per address a, in priority order:
  - flush_i -> 0;
  - alloc_en_i and alloc_addr_i==a -> 1 (the new producer overrides a same-cycle writeback to a);
  - any enabled write to a -> 0;
  - else hold.
- Allocation of address 0 with ZERO_REG=1 is ignored.
- Allocating an already-pending register leaves it pending (no error, no count change).
- Writes to non-pending registers are legal and leave the bit at 0.
- rbusy_k = pend[raddr_k], but forced to 0 when:
  - ZERO_REG and raddr_k==0, or
  - BYPASS and an enabled write hits raddr_k this cycle.
- Same-cycle alloc does not affect rbusy (visible next cycle).
- pend_cnt_o is registered and always equals the popcount of the pending bits after the edge. It is updated incrementally: +1 on a new set, -1 for each distinct cleared address (several write ports may clear different registers in one cycle). A write to the address being allocated counts as no change. flush_i forces 0.
- pend_cnt_o saturation is not needed: the maximum is 2**ADDR_W, which fits ADDR_W+1 bits.
- Out-of-range packed fields do not exist; all addresses are valid.

Test Plan:
- Reset, then write port0 addr 3 = 0xDEADBEEF; same cycle read port1 addr 3 -> BYPASS=1 shows 0xDEADBEEF; BYPASS=0 shows 0, then 0xDEADBEEF next cycle.
- wen on ports 0 and 1 both to addr 7 (0x11, 0x22) -> reg7 = 0x22; a same-cycle read of 7 also returns 0x22.
- Write 0x55 to addr 0 and alloc addr 0 with ZERO_REG=1 -> read addr 0 = 0, rbusy 0, pend_cnt_o stays 0.
- Scoreboard sequence:
  - alloc 5 -> next cycle rbusy on addr 5 = 1, pend_cnt_o = 1;
  - alloc 9 -> pend_cnt_o = 2;
  - in one cycle, write 5 on port0, write 9 on port1, and read 5 -> rbusy 0 that cycle, pend_cnt_o = 0 after.
- alloc 4 together with a write to 4 -> reg4 updated and pend[4] = 1, pend_cnt_o +1. Then alloc 6 plus flush_i -> all pending cleared, pend_cnt_o = 0, reg4 keeps its value.
- Assert rst_i low asynchronously mid-cycle after several writes and allocs -> rdata_o, rbusy_o and pend_cnt_o all go to 0 without waiting for a clock edge.
